// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
//   N-to-1 multiplexer for one crossbar output port. A round-robin arbiter
//   chooses an input channel, and the winning word is captured in an output
//   register with a valid/ready handshake.
//
//   Build option:
//     RR_MUX_FIXED_PRIO_EN defined   -> fixed priority, lowest valid index wins
//                                       (no priority pointer is kept)
//     RR_MUX_FIXED_PRIO_EN undefined -> round-robin (default)
//
//   Ports:
//     CLK      in   rising-edge clock
//     RST_N    in   asynchronous reset, active-low
//     X        in   flattened channel data, channel i at [i*Data_Width +: Data_Width]
//     X_VALID  in   per-channel valid
//     X_READY  out  per-channel accept strobe, one-hot or zero
//     Y        out  registered output word
//     Y_VALID  out  Y holds a word
//     Y_READY  in   downstream accepts Y
//     S        out  registered index of the channel whose word is in Y
// -----------------------------------------------------------------------------
module rr_mux_arbiter #(
  parameter int Data_Width = 8,
  parameter int Num_Inputs = 4,
  parameter int Sel_Width  = (Num_Inputs > 1) ? $clog2(Num_Inputs) : 1
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic [Num_Inputs*Data_Width-1:0] X,
  input  logic [Num_Inputs-1:0]            X_VALID,
  output logic [Num_Inputs-1:0]            X_READY,
  output logic [Data_Width-1:0]            Y,
  output logic                             Y_VALID,
  input  logic                             Y_READY,
  output logic [Sel_Width-1:0]             S
);

  logic                  load;
  logic                  found;
  logic [Sel_Width-1:0]  g;
  logic [Data_Width-1:0] x_ch [Num_Inputs];

  for (genvar i = 0; i < Num_Inputs; i++) begin : g_unpack
    assign x_ch[i] = X[i*Data_Width +: Data_Width];
  end

  // Output register is empty or is being drained this cycle.
  assign load = ~Y_VALID | Y_READY;

`ifdef RR_MUX_FIXED_PRIO_EN
  // Walk downward so the lowest-index valid channel is the last one written.
  always_comb begin
    found = 1'b0;
    g     = '0;
    for (int i = Num_Inputs - 1; i >= 0; i--) begin
      if (X_VALID[i]) begin
        found = 1'b1;
        g     = Sel_Width'(i);
      end
    end
  end
`else
  // Index of the most recent grant; the search starts just after it.
  logic [Sel_Width-1:0] ptr;

  // Each channel's distance from ptr+1 (modulo Num_Inputs); the valid
  // channel with the smallest distance is the round-robin winner.
  always_comb begin
    int best_d;
    int d;
    found  = 1'b0;
    g      = '0;
    best_d = Num_Inputs;
    d      = 0;
    for (int i = 0; i < Num_Inputs; i++) begin
      d = (i + Num_Inputs - 1 - int'(ptr)) % Num_Inputs;
      if (X_VALID[i] && (d < best_d)) begin
        best_d = d;
        found  = 1'b1;
        g      = Sel_Width'(i);
      end
    end
  end
`endif

  // Gated by RST_N so nothing is accepted while reset is held, even though
  // the cleared output register would otherwise look ready to load.
  always_comb begin
    X_READY = '0;
    if (RST_N && load && found) begin
      X_READY[g] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Y       <= '0;
      Y_VALID <= 1'b0;
      S       <= '0;
`ifndef RR_MUX_FIXED_PRIO_EN
      ptr     <= Sel_Width'(Num_Inputs - 1);
`endif
    end else if (load) begin
      if (found) begin
        Y       <= x_ch[g];
        S       <= g;
        Y_VALID <= 1'b1;
`ifndef RR_MUX_FIXED_PRIO_EN
        ptr     <= g;
`endif
      end else begin
        Y_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_arbiter
//   Self-checking bench for rr_mux_arbiter (Data_Width=8, Num_Inputs=4).
//   Table-driven vectors, hand-written corner sequences and a randomized run
//   compared against a behavioural reference model. Follows the
//   RR_MUX_FIXED_PRIO_EN build option.
// -----------------------------------------------------------------------------
module tb_rr_mux_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic [N*W-1:0] X;
  logic [N-1:0] X_VALID;
  logic [N-1:0] X_READY;
  logic [W-1:0] Y;
  logic         Y_VALID;
  logic         Y_READY;
  logic [1:0]   S;

  rr_mux_arbiter #(.Data_Width(W), .Num_Inputs(N)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .X       (X),
    .X_VALID (X_VALID),
    .X_READY (X_READY),
    .Y       (Y),
    .Y_VALID (Y_VALID),
    .Y_READY (Y_READY),
    .S       (S)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] xd [N];
  logic [N-1:0] seen_ready;

  // reference model state
  logic [W-1:0] m_y;
  logic         m_valid;
  int           m_s;
  int           m_last;

  typedef struct {
    logic [N-1:0]   xv;
    logic [N*W-1:0] xdat;
    logic           yr;
    logic [N-1:0]   er;
    logic [W-1:0]   ey;
    logic           ev;
    logic [1:0]     es;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [N-1:0] v, input logic yr);
    X_VALID = v;
    Y_READY = yr;
    X       = {xd[3], xd[2], xd[1], xd[0]};
  endtask

  task automatic model_reset();
    m_y     = '0;
    m_valid = 1'b0;
    m_s     = 0;
    m_last  = N - 1;
  endtask

  // Winner among the valid channels, -1 when none is valid.
  function automatic int model_pick(input logic [N-1:0] v);
`ifdef RR_MUX_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
`else
    for (int d = 1; d <= N; d++) begin
      int c;
      c = (m_last + d) % N;
      if (v[c]) return c;
    end
    return -1;
`endif
  endfunction

  // One clock: check X_READY before the edge, advance the model with the
  // pre-edge inputs, then check the registered outputs 1 ns after the edge.
  task automatic cycle(input string tag);
    int           c;
    logic         ld;
    logic [N-1:0] er;
    #1;
    c  = model_pick(X_VALID);
    ld = !m_valid || Y_READY;
    er = '0;
    if (ld && c >= 0) er[c] = 1'b1;
    seen_ready = X_READY;
    chk({tag, " x_ready"}, X_READY, er);
    @(posedge CLK);
    if (ld) begin
      if (c >= 0) begin
        m_y     = xd[c];
        m_s     = c;
        m_valid = 1'b1;
        m_last  = c;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk({tag, " y"},       Y,       m_y);
    chk({tag, " y_valid"}, Y_VALID, m_valid);
    chk({tag, " s"},       S,       m_s);
  endtask

  task automatic set_words(input logic [N*W-1:0] w);
    for (int j = 0; j < N; j++) xd[j] = w[j*W +: W];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef RR_MUX_FIXED_PRIO_EN
    for (int k = 0; k < 5; k++)
      tbl.push_back('{4'hF, 32'h44332211, 1'b1, 4'b0001, 8'h11, 1'b1, 2'd0});
    for (int k = 0; k < 3; k++)
      tbl.push_back('{4'b0100, 32'h44A52211, 1'b1, 4'b0100, 8'hA5, 1'b1, 2'd2});
    for (int k = 0; k < 4; k++)
      tbl.push_back('{4'b1010, 32'h44332211, 1'b1, 4'b0010, 8'h22, 1'b1, 2'd1});
`else
    tbl.push_back('{4'hF, 32'h44332211, 1'b1, 4'b0001, 8'h11, 1'b1, 2'd0});
    tbl.push_back('{4'hF, 32'h44332211, 1'b1, 4'b0010, 8'h22, 1'b1, 2'd1});
    tbl.push_back('{4'hF, 32'h44332211, 1'b1, 4'b0100, 8'h33, 1'b1, 2'd2});
    tbl.push_back('{4'hF, 32'h44332211, 1'b1, 4'b1000, 8'h44, 1'b1, 2'd3});
    tbl.push_back('{4'hF, 32'h44332211, 1'b1, 4'b0001, 8'h11, 1'b1, 2'd0});
    for (int k = 0; k < 3; k++)
      tbl.push_back('{4'b0100, 32'h44A52211, 1'b1, 4'b0100, 8'hA5, 1'b1, 2'd2});
`endif

    // reset with all channels valid, release at 100 ns
    RST_N = 1'b0;
    set_words(32'h44332211);
    apply(4'hF, 1'b1);
    model_reset();
    #50;
    chk("rst x_ready", X_READY, 4'b0000);
    chk("rst y_valid", Y_VALID, 1'b0);
    #50;
    RST_N = 1'b1;
    #1;
    chk("post_rst y_valid", Y_VALID, 1'b0);
    chk("post_rst y",       Y,       8'h00);
    chk("post_rst s",       S,       2'd0);

    foreach (tbl[i]) begin
      vec_t r;
      r = tbl[i];
      set_words(r.xdat);
      apply(r.xv, r.yr);
      cycle($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d exp_ready", i), seen_ready, r.er);
      chk($sformatf("tbl%0d exp_y", i),     Y,          r.ey);
      chk($sformatf("tbl%0d exp_valid", i), Y_VALID,    r.ev);
      chk($sformatf("tbl%0d exp_s", i),     S,          r.es);
    end

    // backpressure: hold Y=11 for 3 stalled cycles
    RST_N = 1'b0;
    model_reset();
    #4;
    RST_N = 1'b1;
    set_words(32'h44332211);
    apply(4'hF, 1'b1);
    cycle("bp_load");
    chk("bp_load y", Y, 8'h11);
    for (int k = 0; k < 3; k++) begin
      apply(4'hF, 1'b0);
      cycle($sformatf("bp_stall%0d", k));
      chk("bp_stall ready", seen_ready, 4'b0000);
      chk("bp_stall y",     Y,          8'h11);
      chk("bp_stall s",     S,          2'd0);
      chk("bp_stall valid", Y_VALID,    1'b1);
    end
    apply(4'hF, 1'b1);
    cycle("bp_release");
`ifdef RR_MUX_FIXED_PRIO_EN
    chk("bp_release ready", seen_ready, 4'b0001);
    chk("bp_release y",     Y,          8'h11);
`else
    chk("bp_release ready", seen_ready, 4'b0010);
    chk("bp_release y",     Y,          8'h22);
    chk("bp_release s",     S,          2'd1);
`endif

    // idle for 5 cycles, then channels 0 and 3
    for (int k = 0; k < 5; k++) begin
      apply(4'b0000, 1'b1);
      cycle($sformatf("idle%0d", k));
      chk("idle valid", Y_VALID, 1'b0);
    end
    apply(4'b1001, 1'b1);
    cycle("after_idle0");
`ifdef RR_MUX_FIXED_PRIO_EN
    chk("after_idle0 s", S, 2'd0);
`else
    chk("after_idle0 s", S, 2'd3);
    chk("after_idle0 y", Y, 8'h44);
`endif
    cycle("after_idle1");
    chk("after_idle1 s", S, 2'd0);
    chk("after_idle1 y", Y, 8'h11);

`ifdef RR_MUX_FIXED_PRIO_EN
    // channels 1 and 3 valid: channel 3 must never win
    for (int k = 0; k < 6; k++) begin
      apply(4'b1010, 1'b1);
      cycle($sformatf("fixed13_%0d", k));
      chk("fixed13 s", S, 2'd1);
    end
`endif

    // reset mid-stream while stalled
    apply(4'hF, 1'b0);
    cycle("pre_rst_stall");
    chk("pre_rst valid", Y_VALID, 1'b1);
    #1;
    RST_N = 1'b0;
    #1;
    chk("mid_rst y_valid", Y_VALID, 1'b0);
    chk("mid_rst y",       Y,       8'h00);
    chk("mid_rst s",       S,       2'd0);
    chk("mid_rst x_ready", X_READY, 4'b0000);
    model_reset();
    #2;
    RST_N = 1'b1;
    apply(4'hF, 1'b1);
    cycle("mid_rst_first");
    chk("mid_rst_first s", S, 2'd0);
    chk("mid_rst_first y", Y, 8'h11);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      for (int j = 0; j < N; j++) xd[j] = W'($urandom);
      apply(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      cycle($sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
